// File: rtl/posit_decode_pkg.sv
// Shared field layout, bias and special encodings for the 12-bit eposit
// working format produced by the posit8 decoder.
package posit_decode_pkg;

    localparam int INF_BIT  = 11;
    localparam int ZERO_BIT = 10;
    localparam int SIGN_BIT = 9;
    localparam int EXP_MSB  = 8;
    localparam int EXP_LSB  = 5;
    localparam int FRAC_MSB = 4;
    localparam int FRAC_LSB = 0;

    localparam logic [3:0]  EXP_BIAS    = 4'd7;
    localparam logic [11:0] EPOSIT_INF  = 12'h800;
    localparam logic [11:0] EPOSIT_ZERO = 12'h400;

    // flip = run polarity xor sign; a set flip means the exponent grows with
    // the run length, otherwise it shrinks.
    function automatic logic [3:0] regime_exp(input logic flip, input logic [2:0] run_len);
        if (flip)
            return EXP_BIAS - 4'd1 + {1'b0, run_len};
        else
            return EXP_BIAS - {1'b0, run_len};
    endfunction

endpackage

// File: rtl/posit_regime_count.sv
// Combinational leading-run detector for the 7-bit posit body: run polarity,
// run length and the fraction bits left over after regime and terminator.
module posit_regime_count (
    input  logic [6:0] body,
    output logic       polarity,
    output logic [2:0] run_len,
    output logic [4:0] frac
);

    // run_mask[gi] is set while body[6] .. body[6-gi] all match body[6]
    logic [6:0] run_mask;

    assign run_mask[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < 7; gi++) begin : g_run
            assign run_mask[gi] = run_mask[gi-1] & (body[6-gi] == body[6]);
        end
    endgenerate

    always_comb begin
        run_len = 3'd0;
        for (int i = 0; i < 7; i++) begin
            run_len = run_len + {2'b00, run_mask[i]};
        end
    end

    assign polarity = body[6];

    // The run is at least one bit long and the terminator follows it, so the
    // fraction never reaches above body[4]; a full run shifts everything out.
    assign frac = body[4:0] << (run_len - 3'd1);

endmodule

// File: rtl/decode_posit8.sv
// posit8 (es = 0) to 12-bit eposit decoder with a registered output.
// Define DECODE_POSIT8_INPUT_REG_EN to add an input register (latency 2).
module decode_posit8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  posit,
    output logic        out_valid,
    output logic [11:0] eposit
);
    import posit_decode_pkg::*;

    logic       dec_valid;
    logic [7:0] dec_posit;

`ifdef DECODE_POSIT8_INPUT_REG_EN
    logic       valid_in_reg;
    logic [7:0] posit_in_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_in_reg <= 1'b0;
            posit_in_reg <= 8'h00;
        end else begin
            valid_in_reg <= in_valid;
            posit_in_reg <= posit;
        end
    end

    assign dec_valid = valid_in_reg;
    assign dec_posit = posit_in_reg;
`else
    assign dec_valid = in_valid;
    assign dec_posit = posit;
`endif

    logic       polarity;
    logic [2:0] run_len;
    logic [4:0] frac;

    posit_regime_count u_regime (
        .body     (dec_posit[6:0]),
        .polarity (polarity),
        .run_len  (run_len),
        .frac     (frac)
    );

    logic [11:0] eposit_next;

    // The body is used raw: negative posits keep their fraction bits as-is and
    // the sign only changes which way the regime moves the exponent.
    always_comb begin
        eposit_next = EPOSIT_ZERO;
        if (dec_posit == 8'h80) begin
            eposit_next = EPOSIT_INF;
        end else if (dec_posit != 8'h00) begin
            eposit_next                   = 12'h000;
            eposit_next[SIGN_BIT]         = dec_posit[7];
            eposit_next[EXP_MSB:EXP_LSB]  = regime_exp(polarity ^ dec_posit[7], run_len);
            eposit_next[FRAC_MSB:FRAC_LSB] = frac;
        end
    end

    logic [11:0] eposit_reg;
    logic        out_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eposit_reg    <= EPOSIT_ZERO;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= dec_valid;
            if (dec_valid) begin
                eposit_reg <= eposit_next;
            end
        end
    end

    assign eposit    = eposit_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_decode_posit8.sv
// Scoreboard bench for decode_posit8: spec vectors, random back-to-back
// traffic against a bit-walking reference model, hold and async reset.
module tb_decode_posit8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  posit;
    logic        out_valid;
    logic [11:0] eposit;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [11:0] exp_q [$];
    logic [7:0]  pos_q [$];
    int          cyc_q [$];

`ifdef DECODE_POSIT8_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [7:0] TBL_P [12] = '{8'h80, 8'h00, 8'h76, 8'h57, 8'h16, 8'h8a,
                                          8'hea, 8'ha9, 8'h7f, 8'h01, 8'hff, 8'h81};
    localparam logic [11:0] TBL_E [12] = '{12'h800, 12'h400, 12'h138, 12'h0f7, 12'h0ac, 12'h328,
                                           12'h2b4, 12'h2e9, 12'h1a0, 12'h020, 12'h200, 12'h380};

    decode_posit8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .posit     (posit),
        .out_valid (out_valid),
        .eposit    (eposit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: walk the regime bit by bit, then copy remaining bits in order.
    function automatic logic [11:0] model(input logic [7:0] p);
        logic [6:0] b;
        logic       first;
        logic [4:0] f;
        int         i;
        int         m;
        int         k;
        int         e;
        int         pos;
        if (p == 8'h00) return 12'h400;
        if (p == 8'h80) return 12'h800;
        b     = p[6:0];
        first = b[6];
        m     = 0;
        i     = 6;
        while (i >= 0 && b[i] == first) begin
            m++;
            i--;
        end
        k   = first ? m - 1 : -m;
        e   = p[7] ? 6 - k : 7 + k;
        i   = i - 1;
        f   = '0;
        pos = 4;
        for (int j = i; j >= 0; j--) begin
            f[pos] = b[j];
            pos--;
        end
        return {2'b00, p[7], 4'(e), f};
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        posit    = 8'h00;
        repeat (2) @(negedge clk);
        total++;
        if (eposit !== 12'h400) begin
            bad++;
            $display("FAIL reset_eposit got=%h want=%h", eposit, 12'h400);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back(input bit use_table, input int n, input string tag);
        int          idx  = 0;
        int          idle = 0;
        int          c0;
        logic [7:0]  p;
        logic [7:0]  p0;
        logic [11:0] want;
        while (idx < n || (exp_q.size() != 0 && idle < 20)) begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL %s spurious_out got=%h want=none", tag, eposit);
                end else begin
                    want = exp_q.pop_front();
                    p0   = pos_q.pop_front();
                    c0   = cyc_q.pop_front();
                    total++;
                    if (eposit !== want) begin
                        bad++;
                        $display("FAIL %s eposit posit=%h got=%h want=%h", tag, p0, eposit, want);
                    end else begin
                        $display("txn %s posit=%h eposit=%h", tag, p0, eposit);
                    end
                    total++;
                    if (cyc - c0 !== LAT) begin
                        bad++;
                        $display("FAIL %s latency posit=%h got=%0d want=%0d", tag, p0, cyc - c0, LAT);
                    end
                end
            end
            if (idx < n) begin
                if (!use_table && $urandom_range(0, 4) == 0) begin
                    in_valid = 1'b0;
                    posit    = 8'($urandom);
                end else begin
                    if (use_table) begin
                        p = TBL_P[idx];
                        exp_q.push_back(TBL_E[idx]);
                    end else begin
                        p = 8'($urandom);
                        if ($urandom_range(0, 9) == 0) p = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'h00;
                        exp_q.push_back(model(p));
                    end
                    pos_q.push_back(p);
                    cyc_q.push_back(cyc);
                    in_valid = 1'b1;
                    posit    = p;
                    idx++;
                end
            end else begin
                in_valid = 1'b0;
                idle++;
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s drain_timeout got=%0d pending want=0", tag, exp_q.size());
        end
        exp_q.delete();
        pos_q.delete();
        cyc_q.delete();
    endtask

    task automatic test_hold();
        @(negedge clk);
        in_valid = 1'b1;
        posit    = 8'h57;
        @(negedge clk);
        in_valid = 1'b0;
        posit    = 8'h7f;
        for (int k = 1; k <= LAT + 4; k++) begin
            if (k > 1) @(negedge clk);
            posit = 8'($urandom);
            if (k >= LAT) begin
                total++;
                if (eposit !== 12'h0f7) begin
                    bad++;
                    $display("FAIL hold_eposit cycle=%0d got=%h want=%h", k, eposit, 12'h0f7);
                end
                total++;
                if (out_valid !== (k == LAT)) begin
                    bad++;
                    $display("FAIL hold_out_valid cycle=%0d got=%b want=%b", k, out_valid, k == LAT);
                end
            end
        end
        $display("txn hold posit=57 eposit=%h", eposit);
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        in_valid = 1'b1;
        posit    = 8'h76;
        @(negedge clk);
        posit = 8'h16;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (eposit !== 12'h400) begin
            bad++;
            $display("FAIL midreset_eposit got=%h want=%h", eposit, 12'h400);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_out_valid got=%b want=0", out_valid);
        end
        @(negedge clk);
        total++;
        if (eposit !== 12'h400 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_held got=%h/%b want=400/0", eposit, out_valid);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        posit    = 8'h8a;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (out_valid !== (k == LAT)) begin
                bad++;
                $display("FAIL postreset_out_valid cycle=%0d got=%b want=%b", k, out_valid, k == LAT);
            end
        end
        total++;
        if (eposit !== 12'h328) begin
            bad++;
            $display("FAIL postreset_eposit got=%h want=%h", eposit, 12'h328);
        end
        $display("txn postreset posit=8a eposit=%h", eposit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back(1'b1, 12, "table");
        test_back_to_back(1'b0, 60, "random");
        test_hold();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
